axi_sram_slave: RTL and testbench

- AXI3-style responder (slave) for a single-ported, word-organised on-chip SRAM.
- It terminates the same read and write channels that the CPU's bus master drives. It serves icache 16-beat INCR line fills, dcache uncached single beats and byte/half/word stores.
- It is used as the simulation and FPGA memory behind the master bridge.
- It handles one transaction at a time: either one read burst or one write burst, never both concurrently.

---
 rtl/axi_sram_slave_if.sv | 80 ++++++++
 rtl/axi_sram_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave_if
// Description : AXI3-style read/write channel bundle between a bus master and
//               the on-chip SRAM responder.
//               Slave modport  : AW/W/AR/B-ready inputs, AW/W/AR ready and
//                                B/R channel outputs.
//               Master modport : the mirror image of the slave modport.
// Revision    : 1.0  initial release
// ============================================================================
interface axi_sram_slave_if;
    // Write address channel
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    // Write data channel
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    // Write response channel
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    // Read address channel
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    // Read data channel
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI3-style responder for a single-ported, word-organised SRAM
//               of 2^ADDR_WIDTH 32-bit words. Serves one read or one write
//               burst at a time (FIXED/INCR, narrow sizes, byte strobes).
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               axi  - slave side of axi_sram_slave_if (AW, W, B, AR, R)
// Revision    : 1.0  initial release
// ============================================================================
module axi_sram_slave #(
    parameter int    ADDR_WIDTH = 12,
    parameter string INIT_FILE  = ""
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axi_sram_slave_if.slave    axi
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BAW   = ADDR_WIDTH + 2;   // byte-address width kept internally

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AR_ACK = 3'd1,
        S_R_DATA = 3'd2,
        S_AW_ACK = 3'd3,
        S_W_DATA = 3'd4,
        S_W_RESP = 3'd5
    } state_t;

    // Memory contents survive reset, so the array has no reset branch.
    logic [31:0] mem_q [0:DEPTH-1];

    state_t          state_q,   state_d;
    logic [BAW-1:0]  addr_q,    addr_d;
    logic [3:0]      len_q,     len_d;
    logic [2:0]      size_q,    size_d;
    logic [1:0]      burst_q,   burst_d;
    logic [3:0]      id_q,      id_d;
    logic [3:0]      beat_q,    beat_d;
    logic            awready_q, awready_d;
    logic            wready_q,  wready_d;
    logic            bvalid_q,  bvalid_d;
    logic [3:0]      bid_q,     bid_d;
    logic [1:0]      bresp_q,   bresp_d;
    logic            arready_q, arready_d;
    logic            rvalid_q,  rvalid_d;
    logic            rlast_q,   rlast_d;
    logic [3:0]      rid_q,     rid_d;
    logic [31:0]     rdata_q,   rdata_d;

    logic [BAW-1:0]  w_incr;
    logic [BAW-1:0]  w_next_addr;
    logic            w_we;

    // Byte-granular increment; the internal byte address is exactly BAW bits
    // wide, so the addition wraps modulo 2^ADDR_WIDTH words for free.
    assign w_incr      = {{(BAW-1){1'b0}}, 1'b1} << size_q;
    assign w_next_addr = (burst_q == 2'b00) ? addr_q : (addr_q + w_incr);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        id_d      = id_q;
        beat_d    = beat_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        w_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                beat_d = 4'd0;
                // Read has priority when both address channels are valid.
                if (axi.arvalid) begin
                    addr_d    = axi.araddr[BAW-1:0];
                    len_d     = axi.arlen;
                    size_d    = axi.arsize;
                    burst_d   = axi.arburst;
                    id_d      = axi.arid;
                    arready_d = 1'b1;
                    state_d   = S_AR_ACK;
                end else if (axi.awvalid) begin
                    addr_d    = axi.awaddr[BAW-1:0];
                    len_d     = axi.awlen;
                    size_d    = axi.awsize;
                    burst_d   = axi.awburst;
                    id_d      = axi.awid;
                    awready_d = 1'b1;
                    state_d   = S_AW_ACK;
                end
            end

            S_AR_ACK: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b1;
                rdata_d   = mem_q[addr_q[BAW-1:2]];
                rid_d     = id_q;
                rlast_d   = (len_q == 4'd0);
                state_d   = S_R_DATA;
            end

            S_R_DATA: begin
                if (axi.rready) begin
                    if (beat_q == len_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        beat_d   = 4'd0;
                        state_d  = S_IDLE;
                    end else begin
                        addr_d  = w_next_addr;
                        beat_d  = beat_q + 4'd1;
                        rdata_d = mem_q[w_next_addr[BAW-1:2]];
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end
                end
            end

            S_AW_ACK: begin
                awready_d = 1'b0;
                wready_d  = 1'b1;
                state_d   = S_W_DATA;
            end

            S_W_DATA: begin
                if (axi.wvalid) begin
                    w_we   = 1'b1;
                    addr_d = w_next_addr;
                    beat_d = beat_q + 4'd1;
                    // An early or missing wlast still closes the burst; beats
                    // already written stay in memory and the response flags it.
                    if (axi.wlast || (beat_q == len_q)) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (axi.wlast && (beat_q == len_q)) ? 2'b00 : 2'b10;
                        state_d  = S_W_RESP;
                    end
                end
            end

            S_W_RESP: begin
                if (axi.bready) begin
                    bvalid_d = 1'b0;
                    beat_d   = 4'd0;
                    state_d  = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            id_q      <= 4'd0;
            beat_q    <= 4'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            beat_q    <= beat_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Byte-lane write port; lanes with a clear strobe keep their old value.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (axi.wstrb[i]) begin
                    mem_q[addr_q[BAW-1:2]][8*i +: 8] <= axi.wdata[8*i +: 8];
                end
            end
        end
    end

    assign axi.awready = awready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = arready_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = 2'b00;

    // Channel fields the responder does not act on.
    wire w_unused = &{1'b0, axi.awlock, axi.awcache, axi.awprot, axi.wid,
                      axi.arlock, axi.arcache, axi.arprot,
                      axi.awaddr[31:BAW], axi.araddr[31:BAW]};

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Directed bench for axi_sram_slave. Stimulus tasks push the
//               expected R beats and B responses into queues; a monitor pops
//               and compares them whenever the DUT completes a handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_sram_slave;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic        last;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_sram_slave_if bus ();

    axi_sram_slave #(.ADDR_WIDTH(12), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus.slave)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_checks = 0;
    rexp_t       rq[$];
    bexp_t       bq[$];
    int          acc_cyc[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic        bp_mode = 1'b0;
    logic [3:0]  bp_pat = 4'b1001;   // bit k = rready on stall-pattern step k
    int          bp_k = 0;
    logic        coll_mode = 1'b0;
    time         t_ar = 0;
    time         t_aw = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.rvalid) begin
                check("r_stall_rdata", bus.rdata, prev_data);
                check("r_stall_rlast", {31'd0, bus.rlast}, {31'd0, prev_last});
            end
            if (bus.rvalid && bus.rready) begin
                rexp_t e;
                acc_cyc.push_back(cyc);
                check("r_expected_beat", {31'd0, rq.size() != 0}, 32'd1);
                if (rq.size() != 0) begin
                    e = rq.pop_front();
                    check("rid",   {28'd0, bus.rid}, {28'd0, e.id});
                    check("rdata", bus.rdata, e.data);
                    check("rlast", {31'd0, bus.rlast}, {31'd0, e.last});
                    check("rresp", {30'd0, bus.rresp}, 32'd0);
                end
            end
            prev_stall = bus.rvalid && !bus.rready;
            prev_data  = bus.rdata;
            prev_last  = bus.rlast;
            if (bus.bvalid && bus.bready) begin
                bexp_t b;
                check("b_expected_resp", {31'd0, bq.size() != 0}, 32'd1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    check("bid",   {28'd0, bus.bid},   {28'd0, b.id});
                    check("bresp", {30'd0, bus.bresp}, {30'd0, b.resp});
                end
            end
        end
    end

    // rready: held high, or the 1,0,0,1 stall pattern in backpressure mode.
    initial begin
        bus.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.rready = bp_pat[bp_k % 4];
                bp_k++;
            end else begin
                bus.rready = 1'b1;
            end
        end
    end

    task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic last);
        rq.push_back({id, data, last});
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        bq.push_back({id, resp});
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        @(posedge clk);
        #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = len;
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.arready && n < 100);
        check("ar_handshake", {31'd0, bus.arready}, 32'd1);
        t_ar = $time;
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
    endtask

    // Sends nbeats beats from wd/ws; wlast rides on the final beat sent.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats);
        int n;
        @(posedge clk);
        #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len;
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.awready && n < 100);
        check("aw_handshake", {31'd0, bus.awready}, 32'd1);
        t_aw = $time;
        if (coll_mode)
            check("coll_read_done_before_aw", {31'd0, (rq.size() == 0) && !bus.rvalid}, 32'd1);
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.wdata = wd[b]; bus.wstrb = ws[b];
            bus.wlast = (b == nbeats - 1); bus.wvalid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.wready && n < 50);
            check("w_handshake", {31'd0, bus.wready}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(rq.size() == 0 && bq.size() == 0 && !bus.rvalid && !bus.bvalid) && n < 300);
        check(name, {31'd0, rq.size() == 0 && bq.size() == 0}, 32'd1);
        rq.delete();
        bq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.wvalid = 0;
        bus.bready = 1'b1;
        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'd0, bus.awready}, 32'd0);
        check("rst_wready",  {31'd0, bus.wready},  32'd0);
        check("rst_bvalid",  {31'd0, bus.bvalid},  32'd0);
        check("rst_bid",     {28'd0, bus.bid},     32'd0);
        check("rst_bresp",   {30'd0, bus.bresp},   32'd0);
        check("rst_arready", {31'd0, bus.arready}, 32'd0);
        check("rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
        check("rst_rlast",   {31'd0, bus.rlast},   32'd0);
        check("rst_rid",     {28'd0, bus.rid},     32'd0);
        check("rst_rdata",   bus.rdata,            32'd0);
        check("rst_rresp",   {30'd0, bus.rresp},   32'd0);
        rst = 1'b0;

        // Fill words 0x40..0x4F with 0..15, then a 16-beat INCR line fill.
        for (int k = 0; k < 16; k++) begin wd[k] = k; ws[k] = 4'hF; end
        push_b(4'd0, 2'b00);
        do_write(4'd0, 32'h100, 4'd15, 3'd2, 2'b01, 16);
        wait_idle("idle_after_fill_write");
        acc_cyc.delete();
        for (int k = 0; k < 16; k++) push_r(4'd0, k, k == 15);
        do_read(4'd0, 32'h100, 4'd15, 3'd2, 2'b01);
        wait_idle("idle_after_linefill");
        check("linefill_beats", acc_cyc.size(), 32'd16);
        if (acc_cyc.size() == 16)
            check("linefill_back_to_back", acc_cyc[15] - acc_cyc[0], 32'd15);

        // Byte store into lane 1 over a prior full-word value.
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        push_b(4'd4, 2'b00);
        do_write(4'd4, 32'h20, 4'd0, 3'd2, 2'b01, 1);
        wait_idle("idle_after_word_write");
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0010;
        push_b(4'd1, 2'b00);
        do_write(4'd1, 32'h20, 4'd0, 3'd0, 2'b01, 1);
        wait_idle("idle_after_byte_store");
        push_r(4'd2, 32'h1122CC44, 1'b1);
        do_read(4'd2, 32'h20, 4'd0, 3'd2, 2'b01);
        wait_idle("idle_after_byte_readback");

        // Backpressure: 4-beat read with rready pattern 1,0,0,1.
        acc_cyc.delete();
        for (int k = 0; k < 4; k++) push_r(4'd5, k, k == 3);
        bp_k = 0;
        bp_mode = 1'b1;
        do_read(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
        wait_idle("idle_after_backpressure");
        bp_mode = 1'b0;
        check("bp_accepted_beats", acc_cyc.size(), 32'd4);

        // FIXED burst re-reads the same word.
        for (int k = 0; k < 3; k++) push_r(4'd6, 32'd1, k == 2);
        do_read(4'd6, 32'h104, 4'd2, 3'd2, 2'b00);
        wait_idle("idle_after_fixed");

        // Narrow INCR (1 byte per beat) crosses into the next word on beat 4.
        for (int k = 0; k < 5; k++) push_r(4'd7, (k == 4) ? 32'd1 : 32'd0, k == 4);
        do_read(4'd7, 32'h100, 4'd4, 3'd0, 2'b01);
        wait_idle("idle_after_narrow");

        // Protocol error: awlen=3 but wlast on beat 1.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        push_b(4'd3, 2'b00);
        do_write(4'd3, 32'h208, 4'd0, 3'd2, 2'b01, 1);
        wait_idle("idle_after_preset");
        wd[0] = 32'h000000A0; wd[1] = 32'h000000A1; ws[0] = 4'hF; ws[1] = 4'hF;
        push_b(4'd3, 2'b10);
        do_write(4'd3, 32'h200, 4'd3, 3'd2, 2'b01, 2);
        wait_idle("idle_after_short_burst");
        push_r(4'd8, 32'h000000A0, 1'b0);
        push_r(4'd8, 32'h000000A1, 1'b0);
        push_r(4'd8, 32'hDEADBEEF, 1'b1);
        do_read(4'd8, 32'h200, 4'd2, 3'd2, 2'b01);
        wait_idle("idle_after_short_readback");

        // Address wrap at the top word and upper-address aliasing.
        wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
        push_b(4'hA, 2'b00);
        do_write(4'hA, 32'h3FFC, 4'd1, 3'd2, 2'b01, 2);
        wait_idle("idle_after_wrap_write");
        push_r(4'hB, 32'h55, 1'b0);
        push_r(4'hB, 32'h66, 1'b1);
        do_read(4'hB, 32'h3FFC, 4'd1, 3'd2, 2'b01);
        wait_idle("idle_after_wrap_read");
        push_r(4'hC, 32'h66, 1'b1);
        do_read(4'hC, 32'h1000_0000, 4'd0, 3'd2, 2'b01);
        wait_idle("idle_after_alias_read");

        // Collision: AR and AW raised together; read must be served first.
        coll_mode = 1'b1;
        push_r(4'hD, 32'h1122CC44, 1'b1);
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        push_b(4'hE, 2'b00);
        fork
            do_read(4'hD, 32'h20, 4'd0, 3'd2, 2'b01);
            do_write(4'hE, 32'h300, 4'd0, 3'd2, 2'b01, 1);
        join
        coll_mode = 1'b0;
        wait_idle("idle_after_collision");
        check("coll_ar_before_aw", {31'd0, t_ar < t_aw}, 32'd1);
        push_r(4'hF, 32'h12345678, 1'b1);
        do_read(4'hF, 32'h300, 4'd0, 3'd2, 2'b01);
        wait_idle("idle_after_coll_readback");

        // Asynchronous reset in the middle of a 16-beat read.
        acc_cyc.delete();
        for (int k = 0; k < 16; k++) push_r(4'd0, k, k == 15);
        do_read(4'd0, 32'h100, 4'd15, 3'd2, 2'b01);
        for (int n = 0; n < 100 && acc_cyc.size() < 5; n++) begin
            @(negedge clk);
            #1;
        end
        check("rst_test_reached_beat5", {31'd0, acc_cyc.size() >= 5}, 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rvalid",  {31'd0, bus.rvalid},  32'd0);
        check("async_rst_rlast",   {31'd0, bus.rlast},   32'd0);
        check("async_rst_arready", {31'd0, bus.arready}, 32'd0);
        rq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_r(4'd9, 32'h1122CC44, 1'b1);
        do_read(4'd9, 32'h20, 4'd0, 3'd2, 2'b01);
        wait_idle("idle_after_post_reset_read");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
